// File: rtl/ram_pkg.sv
// Shared types and constants for the param_ram block: FSM state encoding
// and the width and saturation helper for the drop counter.
package ram_pkg;

  typedef enum logic {
    INIT = 1'b0,
    IDLE = 1'b1
  } state_t;

  localparam int DROP_W = 8;
  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] value);
    return (value == DROP_MAX) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/ram_core.sv
// Word-addressed storage array with a byte-enabled synchronous write port
// and an asynchronous read port. Deliberately has no reset.
module ram_core #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_W-1:0]     rdata
);

  localparam int NBYTE = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int k = 0; k < NBYTE; k++) begin
        if (be[k]) mem[waddr][8*k +: 8] <= wdata[8*k +: 8];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/param_ram.sv
// Single-port RAM with byte enables, a zeroing sweep after reset or clr,
// a registered read port and a saturating counter of rejected requests.
module param_ram
  import ram_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cen,
  input  logic                  wen,
  input  logic [DATA_W/8-1:0]   s_be,
  input  logic [ADDR_W-1:0]     s_addr,
  input  logic [DATA_W-1:0]     s_din,
  input  logic                  clr,
  output logic [DATA_W-1:0]     s_dout,
  output logic                  s_rvalid,
  output logic                  s_ready,
  output logic [DROP_W-1:0]     drop_cnt
);

  localparam int NBYTE = DATA_W / 8;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t            state, state_next;
  logic [ADDR_W-1:0] clr_ptr, clr_ptr_next;
  logic              accept;
  logic              drop;
  logic              core_we;
  logic [NBYTE-1:0]  core_be;
  logic [ADDR_W-1:0] core_waddr;
  logic [DATA_W-1:0] core_wdata;
  logic [DATA_W-1:0] core_rdata;

  assign s_ready = (state == IDLE);
  assign accept  = cen & s_ready & ~clr;
  assign drop    = cen & ~accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= INIT;
      clr_ptr <= '0;
    end else begin
      state   <= state_next;
      clr_ptr <= clr_ptr_next;
    end
  end

  always_comb begin
    state_next   = state;
    clr_ptr_next = clr_ptr;
    case (state)
      INIT: begin
        if (clr) begin
          clr_ptr_next = '0;
        end else begin
          clr_ptr_next = clr_ptr + 1'b1;
          if (clr_ptr == LAST_ADDR) state_next = IDLE;
        end
      end
      IDLE: begin
        if (clr) begin
          state_next   = INIT;
          clr_ptr_next = '0;
        end
      end
      default: begin
        state_next   = INIT;
        clr_ptr_next = '0;
      end
    endcase
  end

  // The sweep owns the write port while in INIT; held off during reset so
  // memory is only touched once the sweep really starts.
  always_comb begin
    core_we    = 1'b0;
    core_be    = '0;
    core_waddr = s_addr;
    core_wdata = s_din;
    if (state == INIT) begin
      core_we    = rst_n;
      core_be    = '1;
      core_waddr = clr_ptr;
      core_wdata = '0;
    end else begin
      core_we    = accept & wen;
      core_be    = s_be;
    end
  end

  ram_core #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_core (
    .clk   (clk),
    .we    (core_we),
    .be    (core_be),
    .waddr (core_waddr),
    .wdata (core_wdata),
    .raddr (s_addr),
    .rdata (core_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_dout   <= '0;
      s_rvalid <= 1'b0;
      drop_cnt <= '0;
    end else begin
      s_rvalid <= accept & ~wen;
      s_dout   <= (accept && !wen) ? core_rdata : '0;
      if (drop) drop_cnt <= sat_inc(drop_cnt);
    end
  end

endmodule
